// File: rtl/ifid_if.sv
// IF/ID boundary bundle: fetch-side request/return and stall/flush in, decode-side instruction out.
// The stage itself connects through the slave modport.
interface ifid_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_ice;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pc_plus_4;
    logic [DW-1:0] inst_rdata;
    logic [3:0]    stall;
    logic          flush;
    logic [AW-1:0] id_pc;
    logic [AW-1:0] id_pc_plus_4;
    logic [DW-1:0] id_inst;
    logic          id_valid;
    logic          skid_full;
    logic          ovf_err;

    modport master (
        output if_ice, if_pc, if_pc_plus_4, inst_rdata, stall, flush,
        input  id_pc, id_pc_plus_4, id_inst, id_valid, skid_full, ovf_err
    );

    modport slave (
        input  if_ice, if_pc, if_pc_plus_4, inst_rdata, stall, flush,
        output id_pc, id_pc_plus_4, id_inst, id_valid, skid_full, ovf_err
    );
endinterface

// File: rtl/ifid_stage.sv
// IF/ID stage: pairs each synchronous-ROM return with the pc that fetched it and
// parks it in a one-entry skid buffer while decode is stalled.
module ifid_stage #(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic clk,
    input  logic rst,
    ifid_if.slave bus
);
    logic          req_v;
    logic [AW-1:0] req_pc;
    logic [AW-1:0] req_pc4;

    logic          skid_v;
    logic [AW-1:0] skid_pc;
    logic [AW-1:0] skid_pc4;
    logic [DW-1:0] skid_inst;

    logic          id_valid_q;
    logic [AW-1:0] id_pc_q;
    logic [AW-1:0] id_pc4_q;
    logic [DW-1:0] id_inst_q;
    logic          ovf_q;

    logic          hold;
    logic          unused_stall;

    assign hold         = bus.stall[1];
    assign unused_stall = ^{bus.stall[3:2], bus.stall[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            req_v      <= 1'b0;
            req_pc     <= '0;
            req_pc4    <= '0;
            skid_v     <= 1'b0;
            skid_pc    <= '0;
            skid_pc4   <= '0;
            skid_inst  <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_inst_q  <= DW'(NOP_INST);
            ovf_q      <= 1'b0;
        end else begin
            req_pc  <= bus.if_pc;
            req_pc4 <= bus.if_pc_plus_4;
            if (bus.flush) begin
                // Squash everything in flight, including the fetch issued this cycle.
                req_v      <= 1'b0;
                skid_v     <= 1'b0;
                id_valid_q <= 1'b0;
                id_inst_q  <= DW'(NOP_INST);
            end else begin
                req_v <= bus.if_ice;
                if (hold) begin
                    if (req_v) begin
                        if (!skid_v) begin
                            skid_v    <= 1'b1;
                            skid_pc   <= req_pc;
                            skid_pc4  <= req_pc4;
                            skid_inst <= bus.inst_rdata;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end else if (skid_v) begin
                    // Skid is always older than the returning word, so it leaves first.
                    id_valid_q <= 1'b1;
                    id_pc_q    <= skid_pc;
                    id_pc4_q   <= skid_pc4;
                    id_inst_q  <= skid_inst;
                    if (req_v) begin
                        skid_pc   <= req_pc;
                        skid_pc4  <= req_pc4;
                        skid_inst <= bus.inst_rdata;
                    end else begin
                        skid_v <= 1'b0;
                    end
                end else begin
                    id_valid_q <= req_v;
                    if (req_v) begin
                        id_pc_q   <= req_pc;
                        id_pc4_q  <= req_pc4;
                        id_inst_q <= bus.inst_rdata;
                    end else begin
                        id_inst_q <= DW'(NOP_INST);
                    end
                end
            end
        end
    end

    assign bus.id_valid     = id_valid_q;
    assign bus.id_pc        = id_pc_q;
    assign bus.id_pc_plus_4 = id_pc4_q;
    assign bus.id_inst      = id_inst_q;
    assign bus.skid_full    = skid_v;
    assign bus.ovf_err      = ovf_q;
endmodule

// File: tb/tb_ifid_stage.sv
// Directed-vector bench for ifid_stage: one cycle per table row, outputs checked 1ns after the edge.
module tb_ifid_stage;
    localparam logic [31:0] WA = 32'h11111111;
    localparam logic [31:0] WB = 32'h22222222;
    localparam logic [31:0] WC = 32'h33333333;
    localparam logic [31:0] WD = 32'h44444444;
    localparam logic [31:0] WE = 32'h55555555;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ifid_if #(.AW(32), .DW(32)) bus ();

    ifid_stage #(.AW(32), .DW(32), .NOP_INST(32'h00000000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ice;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [3:0]  stall;
        logic        flush;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic        e_skid;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ice, input logic [31:0] pc,
                       input logic [31:0] rd, input logic [3:0] st, input logic fl,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                       input logic [31:0] ep4, input logic es, input logic eo);
        vec_t v;
        v.rst = r; v.ice = ice; v.pc = pc; v.rdata = rd; v.stall = st; v.flush = fl;
        v.e_valid = ev; v.e_inst = ei; v.e_pc = ep; v.e_pc4 = ep4; v.e_skid = es; v.e_ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ice, input logic [31:0] pc,
                         input logic [31:0] rd, input logic [3:0] st, input logic fl);
        rst              = r;
        bus.if_ice       = ice;
        bus.if_pc        = pc;
        bus.if_pc_plus_4 = pc + 32'd4;
        bus.inst_rdata   = rd;
        bus.stall        = st;
        bus.flush        = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input logic ev, input logic [31:0] ei,
                             input logic [31:0] ep, input logic [31:0] ep4,
                             input logic es, input logic eo);
        chk("id_valid",     idx, {31'd0, bus.id_valid},  {31'd0, ev});
        chk("id_inst",      idx, bus.id_inst,            ei);
        chk("id_pc",        idx, bus.id_pc,              ep);
        chk("id_pc_plus_4", idx, bus.id_pc_plus_4,       ep4);
        chk("skid_full",    idx, {31'd0, bus.skid_full}, {31'd0, es});
        chk("ovf_err",      idx, {31'd0, bus.ovf_err},   {31'd0, eo});
    endtask

    initial begin
        // T1 reset with a fetch pending
        add(1, 1, 32'h100, 0,  4'b0000, 0,  0, 0,  0,     0,     0, 0);
        add(1, 1, 32'h100, 0,  4'b0000, 0,  0, 0,  0,     0,     0, 0);
        // T2 stream A,B,C at pc 0,4,8
        add(0, 1, 32'h0,   0,  4'b0000, 0,  0, 0,  0,     0,     0, 0);
        add(0, 1, 32'h4,   WA, 4'b0000, 0,  1, WA, 32'h0, 32'h4, 0, 0);
        add(0, 1, 32'h8,   WB, 4'b0000, 0,  1, WB, 32'h4, 32'h8, 0, 0);
        add(0, 1, 32'hC,   WC, 4'b0000, 0,  1, WC, 32'h8, 32'hC, 0, 0);
        // T3 stall while the pc 0xC word returns, then two more stalled cycles
        add(0, 0, 32'h0,   WE, 4'b0010, 0,  1, WC, 32'h8, 32'hC, 1, 0);
        add(0, 0, 32'h0,   0,  4'b0010, 0,  1, WC, 32'h8, 32'hC, 1, 0);
        add(0, 0, 32'h0,   0,  4'b0010, 0,  1, WC, 32'h8, 32'hC, 1, 0);
        add(0, 0, 32'h0,   0,  4'b0000, 0,  1, WE, 32'hC, 32'h10, 0, 0);
        add(0, 0, 32'h0,   0,  4'b0000, 0,  0, 0,  32'hC, 32'h10, 0, 0);
        // T4 overflow: skid holds A, D is dropped
        add(0, 1, 32'h20,  0,  4'b0000, 0,  0, 0,  32'hC, 32'h10, 0, 0);
        add(0, 1, 32'h24,  WA, 4'b0010, 0,  0, 0,  32'hC, 32'h10, 1, 0);
        add(0, 0, 32'h0,   WD, 4'b0010, 0,  0, 0,  32'hC, 32'h10, 1, 1);
        add(0, 0, 32'h0,   0,  4'b0010, 0,  0, 0,  32'hC, 32'h10, 1, 1);
        add(0, 0, 32'h0,   0,  4'b0000, 0,  1, WA, 32'h20, 32'h24, 0, 1);
        add(0, 0, 32'h0,   0,  4'b0000, 0,  0, 0,  32'h20, 32'h24, 0, 1);
        // T5 flush with skid full and a return in flight, plus a fetch issued in the flush cycle
        add(0, 1, 32'h30,  0,  4'b0000, 0,  0, 0,  32'h20, 32'h24, 0, 1);
        add(0, 1, 32'h34,  WB, 4'b0010, 0,  0, 0,  32'h20, 32'h24, 1, 1);
        add(0, 1, 32'h38,  WC, 4'b0000, 1,  0, 0,  32'h20, 32'h24, 0, 1);
        add(0, 0, 32'h0,   WE, 4'b0000, 0,  0, 0,  32'h20, 32'h24, 0, 1);
        // T6 flush and stall on the same edge
        add(0, 1, 32'h40,  0,  4'b0000, 0,  0, 0,  32'h20, 32'h24, 0, 1);
        add(0, 1, 32'h44,  WA, 4'b0000, 0,  1, WA, 32'h40, 32'h44, 0, 1);
        add(0, 1, 32'h48,  WB, 4'b0010, 0,  1, WA, 32'h40, 32'h44, 1, 1);
        add(0, 0, 32'h0,   WC, 4'b0010, 1,  0, 0,  32'h40, 32'h44, 0, 1);
        add(0, 0, 32'h0,   0,  4'b0000, 0,  0, 0,  32'h40, 32'h44, 0, 1);
        // skid drains while a new word refills it; stall bits other than bit 1 ignored
        add(0, 1, 32'h50,  0,  4'b1101, 0,  0, 0,  32'h40, 32'h44, 0, 1);
        add(0, 1, 32'h54,  WA, 4'b0010, 0,  0, 0,  32'h40, 32'h44, 1, 1);
        add(0, 0, 32'h0,   WB, 4'b0000, 0,  1, WA, 32'h50, 32'h54, 1, 1);
        add(0, 0, 32'h0,   0,  4'b1101, 0,  1, WB, 32'h54, 32'h58, 0, 1);
        add(0, 0, 32'h0,   0,  4'b0000, 0,  0, 0,  32'h54, 32'h58, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ice, vecs[i].pc, vecs[i].rdata, vecs[i].stall, vecs[i].flush);
            check_all(i, vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_pc4,
                      vecs[i].e_skid, vecs[i].e_ovf);
        end

        // Reset while skid is full and stalled: nothing from before reset may emerge, ovf_err clears.
        drive(0, 1, 32'h60, 0,  4'b0000, 0);
        drive(0, 1, 32'h64, WD, 4'b0010, 0);
        check_all(100, 0, 0, 32'h54, 32'h58, 1, 1);
        drive(1, 1, 32'h68, WE, 4'b0010, 0);
        check_all(101, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0,  WC, 4'b0000, 0);
        check_all(102, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0,  0,  4'b0000, 0);
        check_all(103, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
